wb_spim: RTL and testbench

//  Wishbone classic slave that is an SPI *master*, so SERV firmware can drive external SPI devices
//  (sensors, motor drivers). Counterpart of the SPI-slave-to-Wishbone bridge used by the host.

---
 rtl/wb_spim_pkg.sv | 19 +
 rtl/wb_spim_if.sv | 13 +
 rtl/wb_spim_shifter.sv | 78 +++++++
 rtl/wb_spim.sv | 87 ++++++++
 tb/tb_wb_spim.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wb_spim_pkg.sv
// wb_spim_pkg: register map, CTRL layout and shifter state encoding for the Wishbone SPI master
package wb_spim_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam int SB_OVR  = 2;
  localparam int CT_CPOL = 8;
  localparam int CT_CPHA = 9;
  localparam int CT_CS   = 10;
  localparam int CT_IE   = 11;
  typedef struct packed {
    logic       ie;
    logic       cs;
    logic       cpha;
    logic       cpol;
    logic [7:0] div;
  } ctrl_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} spim_state_t;
endpackage

// File: rtl/wb_spim_if.sv
// wb_spim_if: Wishbone classic bus signals between the decoder (master) and wb_spim (slave)
interface wb_spim_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  modport master (output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat, input wb_rdt, wb_ack);
  modport slave (input wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat, output wb_rdt, wb_ack);
endinterface

// File: rtl/wb_spim_shifter.sv
// wb_spim_shifter: SPI byte engine - divider, 16 half-period edge counter, shift register, SCLK/MOSI
module wb_spim_shifter
  import wb_spim_pkg::*;
(
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx
);
  spim_state_t st_q, st_d;
  logic [7:0] cnt_q, cnt_d, sh_q, sh_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, samp_q, samp_d;
  logic tick, lead, trail, last;
  always_comb begin
    tick   = st_q == S_SHIFT && cnt_q == div;
    lead   = tick && !ecnt_q[0];
    trail  = tick && ecnt_q[0];
    last   = tick && ecnt_q == 4'd15;
    st_d   = st_q;
    cnt_d  = cnt_q;
    ecnt_d = ecnt_q;
    sh_d   = sh_q;
    mosi_d = mosi_q;
    samp_d = samp_q;
    if (st_q == S_IDLE && start) begin
      st_d   = S_SHIFT;
      cnt_d  = '0;
      ecnt_d = '0;
      sh_d   = tx;
      mosi_d = cpha ? mosi_q : tx[7];
    end else if (st_q == S_DONE) begin
      st_d = S_IDLE;
    end else if (st_q == S_SHIFT) begin
      cnt_d  = tick ? 8'd0 : cnt_q + 8'd1;
      ecnt_d = tick ? ecnt_q + 4'd1 : ecnt_q;
      st_d   = last ? S_DONE : S_SHIFT;
      // CPHA=0 holds the sampled bit until the trailing edge so MOSI and the shift stay in step
      if (lead && cpha) mosi_d = sh_q[7];
      if (lead && !cpha) samp_d = miso;
      if (trail) sh_d = {sh_q[6:0], cpha ? miso : samp_q};
      if (trail && !cpha && !last) mosi_d = sh_q[6];
    end
    sclk_d = st_d == S_SHIFT ? cpol ^ ecnt_d[0] : cpol;
  end
  always_ff @(posedge wb_clk)
    if (!wb_rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      ecnt_q <= '0;
      sh_q   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      samp_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ecnt_q <= ecnt_d;
      sh_q   <= sh_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      samp_q <= samp_d;
    end
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign busy = st_q != S_IDLE;
  assign done = st_q == S_DONE;
  assign rx   = sh_q;
endmodule

// File: rtl/wb_spim.sv
// wb_spim: Wishbone classic slave exposing DATA/STATUS/CTRL registers of an SPI master
module wb_spim
  import wb_spim_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  wb_spim_if.slave   bus,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_csn,
  output logic       irq
);
  ctrl_t ctrl_q, ctrl_d;
  logic [7:0] rxd_q, rxd_d, rx;
  logic [31:0] rdt_q, rdt_d;
  logic rxv_q, rxv_d, ovr_q, ovr_d, ack_q, ack_d, irq_q, irq_d;
  logic req, wr, rd, start, busy, done;
  logic [1:0] a;
  logic unused_bits;
  always_comb begin
    req   = bus.wb_cyc & bus.wb_stb & ~ack_q;
    wr    = req & bus.wb_we;
    rd    = req & ~bus.wb_we;
    a     = bus.wb_adr[3:2];
    start = wr && a == REG_DATA && bus.wb_sel[0] && !busy;
    // a DATA write landing while the engine is busy (including DONE) is dropped; set wins over W1C
    ovr_d = (wr && a == REG_DATA && bus.wb_sel[0] && busy) ? 1'b1 :
            (wr && a == REG_STATUS && bus.wb_sel[0] && bus.wb_dat[SB_OVR]) ? 1'b0 : ovr_q;
    rxv_d = done ? 1'b1 : (rd && a == REG_DATA) ? 1'b0 : rxv_q;
    rxd_d = done ? rx : rxd_q;
    ctrl_d = ctrl_q;
    if (wr && a == REG_CTRL && bus.wb_sel[0] && !busy) ctrl_d.div = bus.wb_dat[7:0];
    if (wr && a == REG_CTRL && bus.wb_sel[1]) begin
      ctrl_d.cs = bus.wb_dat[CT_CS];
      ctrl_d.ie = bus.wb_dat[CT_IE];
      ctrl_d.cpol = busy ? ctrl_q.cpol : bus.wb_dat[CT_CPOL];
      ctrl_d.cpha = busy ? ctrl_q.cpha : bus.wb_dat[CT_CPHA];
    end
    rdt_d = !rd ? 32'h0 :
            a == REG_DATA   ? {24'h0, rxd_q} :
            a == REG_STATUS ? {29'h0, ovr_q, rxv_q, busy} :
            a == REG_CTRL   ? {20'h0, ctrl_q} : 32'h0;
    ack_d = req;
    irq_d = rxv_d & ctrl_d.ie;
  end
  always_ff @(posedge wb_clk)
    if (!wb_rst_n) begin
      ctrl_q <= '{ie: 1'b0, cs: 1'b0, cpha: 1'b0, cpol: 1'b0, div: DIV_RST};
      rxd_q  <= '0;
      rdt_q  <= '0;
      rxv_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      rxd_q  <= rxd_d;
      rdt_q  <= rdt_d;
      rxv_q  <= rxv_d;
      ovr_q  <= ovr_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
    end
  wb_spim_shifter u_shifter (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .start   (start),
    .tx      (bus.wb_dat[7:0]),
    .div     (ctrl_q.div),
    .cpol    (ctrl_q.cpol),
    .cpha    (ctrl_q.cpha),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .busy    (busy),
    .done    (done),
    .rx      (rx)
  );
  assign bus.wb_rdt  = rdt_q;
  assign bus.wb_ack  = ack_q;
  assign spi_csn     = ~ctrl_q.cs;
  assign irq         = irq_q;
  assign unused_bits = ^{bus.wb_adr[31:4], bus.wb_adr[1:0], bus.wb_dat[31:12], bus.wb_sel[3:2]};
endmodule

// File: tb/tb_wb_spim.sv
// tb_wb_spim: directed bench; bus reads are scoreboarded, SPI pins checked against hand-derived values
module tb_wb_spim;
  logic wb_clk = 1'b0;
  logic wb_rst_n = 1'b0;
  logic spi_sclk, spi_mosi, spi_miso, spi_csn, irq;
  wb_spim_if bus();
  wb_spim #(.DIV_RST(8'd3)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .bus     (bus),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_csn (spi_csn),
    .irq     (irq)
  );
  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad = 0;
  logic [31:0] sb_q[$];
  longint edges_t[$];
  logic mosi_bits[$];
  logic loop = 1'b1;
  logic tb_cpol = 1'b0;
  logic [7:0] slv = 8'h00;
  logic prev_ack = 1'b0;

  // slave model: loopback, or a byte shifted out MSB first, advancing after each trailing SCLK edge
  assign spi_miso = loop ? spi_mosi : slv[7];
  always @(spi_sclk) begin
    edges_t.push_back($time);
    if (spi_sclk == tb_cpol) slv <= {slv[6:0], 1'b0};
  end
  always @(posedge spi_sclk) mosi_bits.push_back(spi_mosi);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge wb_clk) begin
    if (bus.wb_ack === 1'b1) begin
      chk("ack_single_cycle", {31'h0, prev_ack}, 32'h0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected: got rdt %h with no access pending", bus.wb_rdt);
      end else chk("rdt", bus.wb_rdt, sb_q.pop_front());
    end
    prev_ack = bus.wb_ack;
  end

  task automatic acc(input logic we, input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel,
                     input logic [31:0] exp);
    @(negedge wb_clk);
    bus.wb_cyc = 1'b1;
    bus.wb_stb = 1'b1;
    bus.wb_we  = we;
    bus.wb_adr = {28'h0, r, 2'b00};
    bus.wb_dat = d;
    bus.wb_sel = sel;
    sb_q.push_back(we ? 32'h0 : exp);
    @(posedge wb_clk);
    @(negedge wb_clk);
    chk("ack", {31'h0, bus.wb_ack}, 32'h1);
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel);
    acc(1'b1, r, d, sel, 32'h0);
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp);
    acc(1'b0, r, 32'h0, 4'hf, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic chk_edges(input string nm, input int n, input longint gap);
    int g = 0;
    chk({nm, "_count"}, edges_t.size(), n);
    for (int i = 1; i < edges_t.size(); i++) if (edges_t[i] - edges_t[i-1] != gap) g++;
    chk({nm, "_gap"}, g, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_sel = 4'h0; bus.wb_adr = '0; bus.wb_dat = '0;
    idle(3);
    chk("rst_sclk", spi_sclk, 0); chk("rst_mosi", spi_mosi, 0); chk("rst_csn", spi_csn, 1);
    chk("rst_irq", irq, 0); chk("rst_ack", bus.wb_ack, 0); chk("rst_rdt", bus.wb_rdt, 0);
    wb_rst_n = 1'b1;
    rd(2'd1, 32'h0); rd(2'd2, 32'h003); rd(2'd0, 32'h0);
    // mode 0, DIV=0, loopback
    wr(2'd2, 32'h0, 4'h3);
    edges_t.delete(); mosi_bits.delete();
    wr(2'd0, 32'hA5, 4'h1);
    rd(2'd1, 32'h1);
    idle(13);
    rd(2'd1, 32'h1);
    rd(2'd1, 32'h2);
    chk_edges("m0_sclk", 16, 10);
    m = 8'h00;
    for (int i = 0; i < mosi_bits.size(); i++) m = {m[6:0], mosi_bits[i]};
    chk("m0_mosi_count", mosi_bits.size(), 8);
    chk("m0_mosi_bits", m, 8'hA5);
    rd(2'd0, 32'hA5); rd(2'd1, 32'h0);
    chk("m0_mosi_hold", spi_mosi, 1); chk("m0_sclk_idle", spi_sclk, 0);
    // mode 3, DIV=3, slave sends 0x3C
    wr(2'd2, 32'h303, 4'h3);
    tb_cpol = 1'b1;
    idle(1);
    chk("m3_sclk_idle", spi_sclk, 1);
    rd(2'd2, 32'h303);
    edges_t.delete(); slv = 8'h3C; loop = 1'b0;
    wr(2'd0, 32'h81, 4'h1);
    idle(70);
    chk_edges("m3_sclk", 16, 40);
    chk("m3_sclk_after", spi_sclk, 1);
    rd(2'd0, 32'h3C);
    loop = 1'b1;
    // overrun and W1C
    wr(2'd2, 32'h0, 4'h3);
    tb_cpol = 1'b0;
    idle(2);
    wr(2'd0, 32'h5A, 4'h1);
    wr(2'd0, 32'hFF, 4'h1);
    rd(2'd1, 32'h5);
    wr(2'd1, 32'h4, 4'h1);
    rd(2'd1, 32'h1);
    idle(15);
    rd(2'd1, 32'h2); rd(2'd0, 32'h5A); rd(2'd1, 32'h0);
    // CS writable while busy, DIV not
    chk("cs_before", spi_csn, 1);
    wr(2'd0, 32'h66, 4'h1);
    wr(2'd2, 32'h409, 4'h3);
    chk("cs_next_cycle", spi_csn, 0);
    rd(2'd2, 32'h400);
    idle(15);
    rd(2'd0, 32'h66);
    wr(2'd2, 32'h409, 4'h3);
    rd(2'd2, 32'h409);
    wr(2'd2, 32'h800, 4'h3);
    chk("cs_released", spi_csn, 1);
    // irq and read coincident with DONE
    wr(2'd0, 32'h3C, 4'h1);
    chk("irq_busy", irq, 0);
    idle(16);
    chk("irq_done_cycle", irq, 0);
    idle(1);
    chk("irq_set", irq, 1);
    rd(2'd0, 32'h3C);
    chk("irq_cleared", irq, 0);
    wr(2'd0, 32'hC3, 4'h1);
    idle(15);
    rd(2'd0, 32'h3C);
    chk("irq_race_kept", irq, 1);
    rd(2'd1, 32'h2);
    rd(2'd0, 32'hC3);
    chk("irq_race_cleared", irq, 0);
    // reset mid-transfer
    wr(2'd2, 32'hC00, 4'h3);
    wr(2'd0, 32'hFF, 4'h1);
    idle(6);
    chk("mid_csn", spi_csn, 0); chk("mid_mosi", spi_mosi, 1);
    wb_rst_n = 1'b0;
    @(posedge wb_clk);
    @(negedge wb_clk);
    chk("rst2_sclk", spi_sclk, 0); chk("rst2_mosi", spi_mosi, 0); chk("rst2_csn", spi_csn, 1);
    chk("rst2_irq", irq, 0); chk("rst2_ack", bus.wb_ack, 0);
    wb_rst_n = 1'b1;
    rd(2'd1, 32'h0); rd(2'd2, 32'h003); rd(2'd0, 32'h0);
    idle(30);
    chk("rst2_no_irq", irq, 0);
    rd(2'd1, 32'h0);
    idle(2);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
